// File: rtl/uart_tx_feeder_if.sv
// Bundle of CPU-side push signals and UART-side strobe signals for the TX feeder.
// The feeder uses the slave view; the CPU/UART side uses the master view.
interface uart_tx_feeder_if #(parameter int ADDR_W = 4);
   logic              wr;
   logic [7:0]        tx_data;
   logic              clr_overflow;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              idle;
   logic              uart_wr;
   logic [7:0]        uart_tx_data;
   logic              uart_busy;

   modport slave (
      input  wr, tx_data, clr_overflow, uart_busy,
      output full, empty, level, overflow, idle, uart_wr, uart_tx_data
   );

   modport master (
      output wr, tx_data, clr_overflow, uart_busy,
      input  full, empty, level, overflow, idle, uart_wr, uart_tx_data
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: one-cycle write strobes, with a guard
// cycle after each strobe so the transmitter has time to raise busy.
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_feeder_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_WAIT} state_e;

   localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              uart_wr_q, uart_wr_d;
   logic [7:0]        uart_tx_data_q, uart_tx_data_d;
   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        mem_d [DEPTH];

   logic full_w, empty_w, push, pop;

   always_comb begin
      full_w  = (level_q == LVL_FULL);
      empty_w = (level_q == '0);
      pop     = (state_q == ST_IDLE) && !empty_w && !bus.uart_busy;
      // A push into a full FIFO still lands when the head leaves on the same edge.
      push    = bus.wr && (!full_w || pop);

      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      overflow_d     = overflow_q;
      uart_wr_d      = 1'b0;
      uart_tx_data_d = uart_tx_data_q;
      mem_d          = mem_q;

      case (state_q)
         ST_IDLE:  if (pop) state_d = ST_GUARD;
         ST_GUARD: state_d = ST_WAIT;
         ST_WAIT:  if (!bus.uart_busy) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (pop) begin
         uart_wr_d      = 1'b1;
         uart_tx_data_d = mem_q[rd_ptr_q];
         rd_ptr_d       = rd_ptr_q + PTR_ONE;
      end

      if (push) begin
         mem_d[wr_ptr_q] = bus.tx_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      // A drop in the same cycle as a clear wins so no overflow is lost.
      if (bus.wr && !push)        overflow_d = 1'b1;
      else if (bus.clr_overflow)  overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         overflow_q     <= 1'b0;
         uart_wr_q      <= 1'b0;
         uart_tx_data_q <= 8'h00;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         overflow_q     <= overflow_d;
         uart_wr_q      <= uart_wr_d;
         uart_tx_data_q <= uart_tx_data_d;
      end
   end

   // Storage needs no reset; only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (!reset) mem_q <= mem_d;
   end

   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.idle         = empty_w && (state_q == ST_IDLE) && !bus.uart_busy;
   assign bus.uart_wr      = uart_wr_q;
   assign bus.uart_tx_data = uart_tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, ordering, overflow, full push/pop,
// busy-paced streaming with wrap-around and mid-transmission reset.
module tb_uart_tx_feeder;

   logic clk;
   logic reset;
   logic man_busy;
   logic model_en;
   int   busy_cnt;
   int   errors;
   int   checks;
   int   cyc;
   logic prev_wr;
   int   dbl_viol;
   int   busy_viol;
   logic [7:0] out_q[$];
   int   wr_cyc[$];

   uart_tx_feeder_if #(.ADDR_W(4)) bus ();

   uart_tx_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.uart_busy = model_en ? (busy_cnt != 0) : man_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART model: busy for 10 cycles starting the cycle after each strobe.
   always @(posedge clk) begin
      if (!model_en)        busy_cnt <= 0;
      else if (bus.uart_wr) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   // Monitor: collect emitted bytes and flag strobe-rule violations.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.uart_wr === 1'b1) begin
         out_q.push_back(bus.uart_tx_data);
         wr_cyc.push_back(cyc);
         if (prev_wr === 1'b1) dbl_viol++;
         if (model_en && busy_cnt != 0) busy_viol++;
      end
      prev_wr <= bus.uart_wr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int n, input int budget);
      int t;
      t = 0;
      while (out_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      if (out_q.size() < n) begin
         errors++;
         $display("FAIL wait_out: got %0d bytes want %0d within %0d cycles", out_q.size(), n, budget);
      end
      checks++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.wr = 1'b1;
      bus.tx_data = 8'h77;
      tick();
      tick();
      reset = 1'b0;
      bus.wr = 1'b0;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
      checks++;
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
      checks++;
      if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
      checks++;
      if (bus.uart_wr !== 1'b0) begin errors++; $display("FAIL reset_uart_wr: got %b want 0", bus.uart_wr); end
      checks++;
      if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.uart_tx_data); end
      checks++;
      if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
      checks++;
      repeat (4) tick();
      if (out_q.size() != 0) begin errors++; $display("FAIL reset_wr_ignored: got %0d bytes want 0", out_q.size()); end
      checks++;
   endtask

   task automatic test_single();
      out_q.delete();
      bus.wr = 1'b1;
      bus.tx_data = 8'hA5;
      tick();
      bus.wr = 1'b0;
      if (bus.level !== 5'd1) begin errors++; $display("FAIL single_level_k1: got %0d want 1", bus.level); end
      checks++;
      if (bus.uart_wr !== 1'b0) begin errors++; $display("FAIL single_early_wr: got %b want 0", bus.uart_wr); end
      checks++;
      tick();
      if (bus.uart_wr !== 1'b1) begin errors++; $display("FAIL single_wr_k2: got %b want 1", bus.uart_wr); end
      checks++;
      if (bus.uart_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.uart_tx_data); end
      checks++;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL single_level_k2: got %0d want 0", bus.level); end
      checks++;
      tick();
      if (bus.uart_wr !== 1'b0) begin errors++; $display("FAIL single_wr_k3: got %b want 0", bus.uart_wr); end
      checks++;
      if (bus.uart_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h want a5", bus.uart_tx_data); end
      checks++;
      repeat (3) tick();
      if (bus.idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", bus.idle); end
      checks++;
   endtask

   task automatic test_spacing();
      out_q.delete();
      wr_cyc.delete();
      bus.wr = 1'b1;
      bus.tx_data = 8'h11;
      tick();
      bus.tx_data = 8'h22;
      tick();
      bus.wr = 1'b0;
      wait_out(2, 20);
      if (out_q.size() >= 2) begin
         if (out_q[0] !== 8'h11 || out_q[1] !== 8'h22) begin
            errors++; $display("FAIL spacing_order: got %h %h want 11 22", out_q[0], out_q[1]);
         end
         checks++;
         if (wr_cyc[1] - wr_cyc[0] != 3) begin
            errors++; $display("FAIL spacing_gap: got %0d want 3", wr_cyc[1] - wr_cyc[0]);
         end
         checks++;
      end
      repeat (4) tick();
   endtask

   task automatic test_fill_overflow();
      out_q.delete();
      man_busy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.wr = 1'b1;
         bus.tx_data = 8'(i);
         tick();
      end
      bus.wr = 1'b0;
      if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
      checks++;
      if (bus.level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d want 16", bus.level); end
      checks++;
      if (out_q.size() != 0) begin errors++; $display("FAIL fill_no_wr: got %0d strobes want 0", out_q.size()); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", bus.overflow); end
      checks++;
      bus.wr = 1'b1;
      bus.tx_data = 8'hEE;
      tick();
      bus.wr = 1'b0;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      checks++;
      if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", bus.level); end
      checks++;
   endtask

   task automatic test_clr_overflow();
      bus.clr_overflow = 1'b1;
      tick();
      bus.clr_overflow = 1'b0;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", bus.overflow); end
      checks++;
      bus.wr = 1'b1;
      bus.tx_data = 8'hDD;
      bus.clr_overflow = 1'b1;
      tick();
      bus.wr = 1'b0;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop: got %b want 1", bus.overflow); end
      checks++;
      tick();
      bus.clr_overflow = 1'b0;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf2: got %b want 0", bus.overflow); end
      checks++;
      man_busy = 1'b0;
      wait_out(16, 200);
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         if (out_q[i] !== 8'(i)) begin errors++; $display("FAIL drain_byte%0d: got %h want %h", i, out_q[i], 8'(i)); end
         checks++;
      end
      repeat (6) tick();
      if (out_q.size() != 16) begin errors++; $display("FAIL drain_count: got %0d want 16", out_q.size()); end
      checks++;
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
      checks++;
   endtask

   task automatic test_full_pushpop();
      logic [7:0] exp;
      out_q.delete();
      man_busy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.wr = 1'b1;
         bus.tx_data = 8'(8'h10 + i);
         tick();
      end
      man_busy = 1'b0;
      bus.tx_data = 8'h55;
      tick();
      bus.wr = 1'b0;
      if (bus.level !== 5'd16) begin errors++; $display("FAIL pp_level: got %0d want 16", bus.level); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b want 0", bus.overflow); end
      checks++;
      if (bus.uart_wr !== 1'b1 || bus.uart_tx_data !== 8'h10) begin
         errors++; $display("FAIL pp_first: got wr=%b data=%h want wr=1 data=10", bus.uart_wr, bus.uart_tx_data);
      end
      checks++;
      wait_out(17, 300);
      for (int i = 0; i < 17 && i < out_q.size(); i++) begin
         exp = (i == 16) ? 8'h55 : 8'(8'h10 + i);
         if (out_q[i] !== exp) begin errors++; $display("FAIL pp_byte%0d: got %h want %h", i, out_q[i], exp); end
         checks++;
      end
      repeat (6) tick();
   endtask

   task automatic test_back_to_back();
      int n;
      int g;
      out_q.delete();
      model_en = 1'b1;
      n = 0;
      g = 0;
      while (n < 40 && g < 2000) begin
         if (bus.full !== 1'b1) begin
            bus.wr = 1'b1;
            bus.tx_data = 8'(n * 7 + 3);
            n++;
         end else begin
            bus.wr = 1'b0;
         end
         tick();
         g++;
      end
      bus.wr = 1'b0;
      wait_out(40, 1000);
      for (int i = 0; i < 40 && i < out_q.size(); i++) begin
         if (out_q[i] !== 8'(i * 7 + 3)) begin
            errors++; $display("FAIL stream_byte%0d: got %h want %h", i, out_q[i], 8'(i * 7 + 3));
         end
         checks++;
      end
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow: got %b want 0", bus.overflow); end
      checks++;
      if (busy_viol != 0) begin errors++; $display("FAIL stream_wr_in_busy: got %0d want 0", busy_viol); end
      checks++;
      repeat (14) tick();
      model_en = 1'b0;
      repeat (4) tick();
      if (out_q.size() != 40) begin errors++; $display("FAIL stream_count: got %0d want 40", out_q.size()); end
      checks++;
   endtask

   task automatic test_reset_mid();
      man_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.wr = 1'b1;
         bus.tx_data = 8'(8'h61 + i);
         if (i == 2) man_busy = 1'b1;
         tick();
      end
      bus.wr = 1'b0;
      if (bus.level !== 5'd5) begin errors++; $display("FAIL mid_level_pre: got %0d want 5", bus.level); end
      checks++;
      reset = 1'b1;
      man_busy = 1'b0;
      bus.wr = 1'b1;
      bus.tx_data = 8'h99;
      tick();
      reset = 1'b0;
      bus.wr = 1'b0;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", bus.level); end
      checks++;
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
      checks++;
      if (bus.uart_wr !== 1'b0) begin errors++; $display("FAIL mid_uart_wr: got %b want 0", bus.uart_wr); end
      checks++;
      if (bus.idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", bus.idle); end
      checks++;
      out_q.delete();
      bus.wr = 1'b1;
      bus.tx_data = 8'h3C;
      tick();
      bus.wr = 1'b0;
      repeat (20) tick();
      if (out_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", out_q.size()); end
      checks++;
      if (out_q.size() >= 1 && out_q[0] !== 8'h3C) begin
         errors++; $display("FAIL mid_byte: got %h want 3c", out_q[0]);
      end
      checks++;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc = 0;
      prev_wr = 1'b0;
      dbl_viol = 0;
      busy_viol = 0;
      man_busy = 1'b0;
      model_en = 1'b0;
      bus.clr_overflow = 1'b0;
      bus.wr = 1'b0;
      bus.tx_data = 8'h00;
      reset = 1'b1;

      test_reset();
      test_single();
      test_spacing();
      test_fill_overflow();
      test_clr_overflow();
      test_full_pushpop();
      test_back_to_back();
      test_reset_mid();

      if (dbl_viol != 0) begin errors++; $display("FAIL consecutive_wr: got %0d want 0", dbl_viol); end
      checks++;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter: ADDR_W, 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: wr  input  1  push strobe from the CPU side, one byte per cycle high.
REQ-006 Port: tx_data  input  8  byte pushed when wr is high.
REQ-007 Port: clr_overflow  input  1  clears the overflow flag.
REQ-008 Port: full  output  1  FIFO holds DEPTH bytes.
REQ-009 Port: empty  output  1  FIFO holds 0 bytes.
REQ-010 Port: level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
REQ-011 Port: overflow  output  1  sticky flag: a push was dropped.
REQ-012 Port: idle  output  1  high when empty, FSM in IDLE, and uart_busy low.
REQ-013 Port: uart_wr  output  1  one-cycle write strobe to the downstream UART transmitter.
REQ-014 Port: uart_tx_data  output  8  byte presented to the UART; SHALL be valid whenever uart_wr is high.
REQ-015 Port: uart_busy  input  1  UART transmitter busy.

Function
REQ-016 FIFO: circular buffer of DEPTH x 8; read and write pointers of ADDR_W bits SHALL wrap from DEPTH-1 to 0.
REQ-017 Push: wr high and not full -> store tx_data at write pointer, increment pointer; level +1.
REQ-018 Push while full (and no pop in the same cycle) SHALL drop the byte, leave FIFO contents unchanged, and set overflow on the next edge.
REQ-019 Push and pop in the same cycle SHALL both take effect; level unchanged; a push when full SHALL succeed if a pop occurs in the same cycle.
REQ-020 overflow SHALL stay high until clr_overflow or reset; if clr_overflow and a new overflow occur in the same cycle, overflow SHALL be set.
REQ-021 full, empty, and level SHALL be derived from registered state and reflect every push or pop on the edge following it.
REQ-022 FSM states: IDLE, GUARD, WAIT.
REQ-023 IDLE: if !empty and !uart_busy -> uart_tx_data <= head byte, uart_wr <= 1, pop (read pointer +1), go to GUARD; otherwise stay.
REQ-024 GUARD: uart_wr <= 0; uart_busy SHALL be ignored; go to WAIT unconditionally, covering the transmitter's busy-assert latency.
REQ-025 WAIT: stay while uart_busy is high; when uart_busy is low -> IDLE.
REQ-026 uart_wr SHALL be high for exactly one cycle per byte; never high on two consecutive cycles.
REQ-027 uart_tx_data SHALL hold its value from the load until the next load.
REQ-028 Latency: a byte pushed in cycle k into an empty FIFO with the UART not busy SHALL produce uart_wr high in cycle k+2.
REQ-029 Minimum spacing between uart_wr strobes SHALL be 3 cycles (IDLE -> GUARD -> WAIT -> IDLE with busy already low).
REQ-030 Bytes SHALL leave in push order; none SHALL be duplicated or lost except by overflow.

Reset
REQ-031 On reset high at a rising edge: pointers = 0, level = 0, empty = 1, full = 0, overflow = 0, uart_wr = 0, uart_tx_data = 8'h00, FSM = IDLE.
REQ-032 Reset mid-transmission SHALL drop all queued bytes and deassert uart_wr on that edge; the UART's in-flight byte is not this block's concern.
REQ-033 A wr asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-034 Push 8'hA5 once into the empty block with uart_busy low -> uart_wr high one cycle at k+2 with uart_tx_data = 8'hA5; level returns to 0.
REQ-035 Push 16 bytes 0x00..0x0F in consecutive cycles with uart_busy held high -> full = 1, level = 16, no uart_wr; a 17th push -> overflow = 1 and contents unchanged; release busy -> 0x00..0x0F emitted in order.
REQ-036 Model busy as high for 10 cycles, starting 1 cycle after uart_wr; stream 40 bytes with wrap-around -> all 40 emitted in order, one uart_wr per busy period, none during busy.
REQ-037 While full and FSM in IDLE with busy low, push 8'h55 -> pop and push in the same cycle, level stays 16, overflow stays 0, 8'h55 emitted last.
REQ-038 Assert reset while in WAIT with 5 bytes queued -> next cycle level = 0, empty = 1, uart_wr = 0, FSM = IDLE; a subsequent push of 8'h3C emits 8'h3C only.
REQ-039 Set overflow, then pulse clr_overflow -> overflow = 0 on the next cycle; clr_overflow in the same cycle as a dropped push -> overflow = 1.
